wb_ram_arbiter_2to1: RTL and testbench
======================================

# wb_ram_arbiter_2to1

Two-master Wishbone arbiter that shares the single synchronous RAM port (behind the Wishbone-to-RAM sync bridge) between the CPU data bus (master 0) and the instruction-fetch bus (master 1). It holds a registered grant for the full duration of a master's bus cycle (`cyc`), muxes the winning master onto the slave port, and routes `ack` back only to the granted master. Tie-break policy is fixed-priority or round-robin, selected at compile time.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width
- `SEL_WIDTH`, 4, byte-select width
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 (dbus) cycle/strobe/write
- `m0_addr_i`  in  ADDR_WIDTH; `m0_data_i`  in  DATA_WIDTH; `m0_sel_i`  in  SEL_WIDTH
- `m0_data_o`  out  DATA_WIDTH  read data; `m0_ack_o`  out  1  acknowledge
- `m1_*`  same set as m0, for master 1 (ibus)
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to bridge
- `s_addr_o`  out  ADDR_WIDTH; `s_data_o`  out  DATA_WIDTH; `s_sel_o`  out  SEL_WIDTH
- `s_data_i`  in  DATA_WIDTH; `s_ack_i`  in  1  from bridge
- `gnt_o`  out  2  one-hot current grant ({m1,m0}); 2'b00 = idle

## Operation
- States: IDLE, GNT0, GNT1; grant register one-hot, equals state.
- Request of master x: `mx_cyc_i & mx_stb_i`.
- IDLE: no request -> IDLE; one request -> that GNT; both -> per policy.
- GNTx: `mx_cyc_i`=1 -> stay (grant locked across multiple stb/ack beats, no preemption). `mx_cyc_i`=0 -> re-arbitrate same cycle among current requests: other master requesting -> GNTy; only x requesting again (new cyc) -> GNTx; none -> IDLE.
- Slave port: granted master's cyc/stb/we/addr/data/sel passed combinationally; IDLE drives all `s_*_o` to 0.
- `mx_ack_o = s_ack_i & gnt_o[x]`; non-granted ack is always 0. `m0_data_o = m1_data_o = s_data_i` (broadcast, qualified by ack).
- Policy: fixed priority, m0 wins ties; round-robin variant in Configuration.
- `s_ack_i` while IDLE ignored (no ack to any master).

## Timing
- Reset (async assert): state IDLE, `gnt_o`=2'b00, all `s_*_o`=0, `m0_ack_o`=`m1_ack_o`=0, RR pointer = "last served m1".
- Arbitration latency: request sampled at edge N -> `gnt_o` valid and slave port driven from edge N (cycle N+1); first slave `cyc&stb` one cycle after request.
- Handover: granted master drops `cyc` in cycle K -> slave sees `cyc`=0 in K -> new master on slave port in K+1 (exactly one dead cycle, required by bridge phase counter).
- Simultaneous requests from IDLE resolved in one cycle; no combinational path from `s_ack_i` to grant state.
- Reset mid-transaction: grant dropped immediately, slave `cyc` deasserted asynchronously; in-flight ack lost.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: adds 1-bit last-granted register, updated on each entry to GNTx; on tie the master not served last wins. First tie after reset goes to m0.
- Undefined: fixed priority, m0 always wins ties; no pointer register.

## Test plan
- Single m0 write addr 0x100 data 0xDEADBEEF sel 4'hF -> `gnt_o`=01 one cycle later, `s_addr_o`=0x100, `m0_ack_o` pulses once, `m1_ack_o`=0.
- m1 holds cyc over two reads 0x0, 0x4 while m0 requests -> m0 waits until m1 cyc drops; one dead cycle; then `gnt_o`=01.
- Both request from IDLE, continuous re-requests, fixed priority -> m0 granted every time, m1 starved; with `ARB_ROUND_ROBIN_EN` grants alternate 01,10,01,10.
- `s_ack_i` forced high while IDLE -> both acks stay 0, `gnt_o`=00.
- Assert `rst` mid m0 cycle -> same-cycle `s_cyc_o`=0, `gnt_o`=00; after release m1 request granted next cycle.

Source files
------------

// File: rtl/wb_ram_arbiter_2to1_if.sv
// Wishbone point-to-point bus bundle: master drives cycle/strobe/address/write data, slave returns read data and ack.
// Shared by both requesting masters and by the slave-side port of the 2:1 RAM arbiter.
interface wb_ram_arbiter_2to1_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic                  ack;

    modport master (
        output cyc, stb, we, addr, wr_dat, sel,
        input  rd_dat, ack
    );

    modport slave (
        input  cyc, stb, we, addr, wr_dat, sel,
        output rd_dat, ack
    );
endinterface

// File: rtl/wb_ram_arbiter_2to1.sv
// 2:1 Wishbone arbiter for the RAM bridge: grant registered one cycle after request, held for the whole cyc, one dead cycle on handover.
// No backpressure of its own; ack is routed only to the granted master. ARB_ROUND_ROBIN_EN selects round-robin tie-break instead of m0 priority.
module wb_ram_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    wb_ram_arbiter_2to1_if.slave        m0,
    wb_ram_arbiter_2to1_if.slave        m1,
    wb_ram_arbiter_2to1_if.master       s,
    output logic [1:0]                  gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;

    logic req0;
    logic req1;
    logic tie_to_m1;

    assign req0 = m0.cyc & m0.stb;
    assign req1 = m1.cyc & m1.stb;

`ifdef ARB_ROUND_ROBIN_EN
    // Resets to "m1 served last" so the first tie goes to m0.
    logic last_m1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_m1 <= 1'b1;
        end else if (state_nxt == GNT0) begin
            last_m1 <= 1'b0;
        end else if (state_nxt == GNT1) begin
            last_m1 <= 1'b1;
        end
    end

    assign tie_to_m1 = ~last_m1;
`else
    assign tie_to_m1 = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant is locked while the owner keeps cyc; once it drops, re-arbitrate in that same cycle.
    always_comb begin
        state_t arb_pick;
        arb_pick  = IDLE;
        state_nxt = state;

        if (req0 && req1) begin
            arb_pick = tie_to_m1 ? GNT1 : GNT0;
        end else if (req0) begin
            arb_pick = GNT0;
        end else if (req1) begin
            arb_pick = GNT1;
        end

        case (state)
            IDLE:    state_nxt = arb_pick;
            GNT0:    state_nxt = m0.cyc ? GNT0 : arb_pick;
            GNT1:    state_nxt = m1.cyc ? GNT1 : arb_pick;
            default: state_nxt = IDLE;
        endcase
    end

    logic                  mux_cyc;
    logic                  mux_stb;
    logic                  mux_we;
    logic [ADDR_WIDTH-1:0] mux_addr;
    logic [DATA_WIDTH-1:0] mux_wr_dat;
    logic [SEL_WIDTH-1:0]  mux_sel;

    always_comb begin
        mux_cyc    = 1'b0;
        mux_stb    = 1'b0;
        mux_we     = 1'b0;
        mux_addr   = '0;
        mux_wr_dat = '0;
        mux_sel    = '0;
        case (state)
            GNT0: begin
                mux_cyc    = m0.cyc;
                mux_stb    = m0.stb;
                mux_we     = m0.we;
                mux_addr   = m0.addr;
                mux_wr_dat = m0.wr_dat;
                mux_sel    = m0.sel;
            end
            GNT1: begin
                mux_cyc    = m1.cyc;
                mux_stb    = m1.stb;
                mux_we     = m1.we;
                mux_addr   = m1.addr;
                mux_wr_dat = m1.wr_dat;
                mux_sel    = m1.sel;
            end
            default: ;
        endcase
    end

    assign s.cyc    = mux_cyc;
    assign s.stb    = mux_stb;
    assign s.we     = mux_we;
    assign s.addr   = mux_addr;
    assign s.wr_dat = mux_wr_dat;
    assign s.sel    = mux_sel;

    assign gnt_o = state;

    // Read data is broadcast; only the ack tells a master the beat is its own.
    assign m0.ack    = s.ack & gnt_o[0];
    assign m1.ack    = s.ack & gnt_o[1];
    assign m0.rd_dat = s.rd_dat;
    assign m1.rd_dat = s.rd_dat;

endmodule

// File: tb/tb_wb_ram_arbiter_2to1.sv
// Bench for the 2:1 Wishbone RAM arbiter: grant-sequence table, directed corner sequences, random traffic vs. a reference model.
module tb_wb_ram_arbiter_2to1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gnt;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    wb_ram_arbiter_2to1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4)) m0_bus ();
    wb_ram_arbiter_2to1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4)) m1_bus ();
    wb_ram_arbiter_2to1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4)) s_bus ();

    wb_ram_arbiter_2to1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus),
        .gnt_o (gnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int m, input bit c, input bit st, input bit w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
        if (m == 0) begin
            m0_bus.cyc = c; m0_bus.stb = st; m0_bus.we = w;
            m0_bus.addr = a; m0_bus.wr_dat = d; m0_bus.sel = sl;
        end else begin
            m1_bus.cyc = c; m1_bus.stb = st; m1_bus.we = w;
            m1_bus.addr = a; m1_bus.wr_dat = d; m1_bus.sel = sl;
        end
    endtask

    task automatic idle_all();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        s_bus.ack    = 1'b0;
        s_bus.rd_dat = 32'h0;
    endtask

    // Reference model: who owns the bus (-1 = nobody) and who was served last.
    int owner;
    bit last_was_m1;

    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
            return last_was_m1 ? 0 : 1;
`else
            return 0;
`endif
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        owner       = -1;
        last_was_m1 = 1'b1;
    endtask

    task automatic model_step();
        bit cyc_of_owner;
        cyc_of_owner = (owner == 0) ? m0_bus.cyc : (owner == 1) ? m1_bus.cyc : 1'b0;
        if (!cyc_of_owner) begin
            owner = pick(m0_bus.cyc & m0_bus.stb, m1_bus.cyc & m1_bus.stb);
            if (owner >= 0) last_was_m1 = (owner == 1);
        end
    endtask

    task automatic check_outputs();
        logic [1:0]  e_gnt;
        logic        e_cyc, e_stb, e_we;
        logic [31:0] e_addr, e_dat;
        logic [3:0]  e_sel;
        e_gnt = 2'b00; e_cyc = 0; e_stb = 0; e_we = 0; e_addr = 0; e_dat = 0; e_sel = 0;
        if (owner == 0) begin
            e_gnt = 2'b01; e_cyc = m0_bus.cyc; e_stb = m0_bus.stb; e_we = m0_bus.we;
            e_addr = m0_bus.addr; e_dat = m0_bus.wr_dat; e_sel = m0_bus.sel;
        end else if (owner == 1) begin
            e_gnt = 2'b10; e_cyc = m1_bus.cyc; e_stb = m1_bus.stb; e_we = m1_bus.we;
            e_addr = m1_bus.addr; e_dat = m1_bus.wr_dat; e_sel = m1_bus.sel;
        end
        chk("rnd_gnt",   64'(gnt),           64'(e_gnt));
        chk("rnd_cyc",   64'(s_bus.cyc),     64'(e_cyc));
        chk("rnd_stb",   64'(s_bus.stb),     64'(e_stb));
        chk("rnd_we",    64'(s_bus.we),      64'(e_we));
        chk("rnd_addr",  64'(s_bus.addr),    64'(e_addr));
        chk("rnd_wdat",  64'(s_bus.wr_dat),  64'(e_dat));
        chk("rnd_sel",   64'(s_bus.sel),     64'(e_sel));
        chk("rnd_ack0",  64'(m0_bus.ack),    64'(s_bus.ack && owner == 0));
        chk("rnd_ack1",  64'(m1_bus.ack),    64'(s_bus.ack && owner == 1));
        chk("rnd_rdat0", 64'(m0_bus.rd_dat), 64'(s_bus.rd_dat));
        chk("rnd_rdat1", 64'(m1_bus.rd_dat), 64'(s_bus.rd_dat));
    endtask

    typedef struct {
        bit         c0, s0, c1, s1;
        logic [1:0] exp_gnt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        bit c0, c1;

        // Sequence starts from IDLE right after reset; each row is the grant one edge later.
        vecs[0]  = '{1, 1, 0, 0, 2'b01};
        vecs[1]  = '{1, 0, 0, 0, 2'b01};
        vecs[2]  = '{0, 0, 1, 1, 2'b10};
        vecs[3]  = '{1, 1, 1, 0, 2'b10};
        vecs[4]  = '{0, 0, 0, 0, 2'b00};
        vecs[5]  = '{1, 1, 1, 1, 2'b01};
        vecs[6]  = '{0, 0, 1, 1, 2'b10};
        vecs[7]  = '{1, 1, 0, 0, 2'b01};
        vecs[8]  = '{0, 0, 0, 0, 2'b00};
`ifdef ARB_ROUND_ROBIN_EN
        vecs[9]  = '{1, 1, 1, 1, 2'b10};
`else
        vecs[9]  = '{1, 1, 1, 1, 2'b01};
`endif
        vecs[10] = '{0, 1, 0, 0, 2'b00};
        vecs[11] = '{0, 0, 1, 0, 2'b00};

        rst = 1'b1;
        idle_all();
        s_bus.ack = 1'b1;
        #2;
        chk("rst_gnt",  64'(gnt),        64'h0);
        chk("rst_cyc",  64'(s_bus.cyc),  64'h0);
        chk("rst_stb",  64'(s_bus.stb),  64'h0);
        chk("rst_ack0", 64'(m0_bus.ack), 64'h0);
        chk("rst_ack1", 64'(m1_bus.ack), 64'h0);
        @(negedge clk);
        s_bus.ack = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(0, vecs[i].c0, vecs[i].s0, 0, 32'h10 + 32'(i), 32'h0, 4'hF);
            drive(1, vecs[i].c1, vecs[i].s1, 0, 32'h20 + 32'(i), 32'h0, 4'hF);
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), 64'(gnt), 64'(vecs[i].exp_gnt));
        end
        idle_all();
        @(negedge clk);

        // Single m0 write.
        drive(0, 1, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF);
        #1;
        chk("wr_gnt_pre", 64'(gnt),       64'h0);
        chk("wr_cyc_pre", 64'(s_bus.cyc), 64'h0);
        @(negedge clk);
        chk("wr_gnt",  64'(gnt),          64'h1);
        chk("wr_addr", 64'(s_bus.addr),   64'h100);
        chk("wr_dat",  64'(s_bus.wr_dat), 64'hDEADBEEF);
        chk("wr_sel",  64'(s_bus.sel),    64'hF);
        chk("wr_we",   64'(s_bus.we),     64'h1);
        s_bus.ack = 1'b1;
        #1;
        chk("wr_ack0", 64'(m0_bus.ack), 64'h1);
        chk("wr_ack1", 64'(m1_bus.ack), 64'h0);
        @(negedge clk);
        idle_all();
        #1;
        chk("wr_ack0_off", 64'(m0_bus.ack), 64'h0);
        @(negedge clk);
        chk("wr_gnt_end", 64'(gnt), 64'h0);

        // m1 holds cyc over two reads while m0 waits.
        drive(1, 1, 1, 0, 32'h0, 32'h0, 4'hF);
        @(negedge clk);
        chk("rd_gnt1",  64'(gnt),        64'h2);
        chk("rd_addr0", 64'(s_bus.addr), 64'h0);
        drive(0, 1, 1, 1, 32'h200, 32'h55AA55AA, 4'h3);
        s_bus.ack = 1'b1; s_bus.rd_dat = 32'h11111111;
        #1;
        chk("rd_ack1_a", 64'(m1_bus.ack),    64'h1);
        chk("rd_ack0_a", 64'(m0_bus.ack),    64'h0);
        chk("rd_dat_a",  64'(m1_bus.rd_dat), 64'h11111111);
        @(negedge clk);
        drive(1, 1, 1, 0, 32'h4, 32'h0, 4'hF);
        s_bus.rd_dat = 32'h22222222;
        #1;
        chk("rd_gnt_lock", 64'(gnt),        64'h2);
        chk("rd_addr4",    64'(s_bus.addr), 64'h4);
        chk("rd_ack1_b",   64'(m1_bus.ack), 64'h1);
        chk("rd_ack0_b",   64'(m0_bus.ack), 64'h0);
        @(negedge clk);
        drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        s_bus.ack = 1'b0;
        #1;
        chk("ho_dead_cyc", 64'(s_bus.cyc), 64'h0);
        chk("ho_dead_gnt", 64'(gnt),       64'h2);
        @(negedge clk);
        chk("ho_gnt0", 64'(gnt),        64'h1);
        chk("ho_addr", 64'(s_bus.addr), 64'h200);
        chk("ho_cyc",  64'(s_bus.cyc),  64'h1);
        idle_all();
        @(negedge clk);

        // Stray ack while idle.
        s_bus.ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ack0", 64'(m0_bus.ack), 64'h0);
            chk("idle_ack1", 64'(m1_bus.ack), 64'h0);
            chk("idle_gnt",  64'(gnt),        64'h0);
        end
        s_bus.ack = 1'b0;

        // Reset in the middle of an m0 cycle.
        drive(0, 1, 1, 0, 32'h300, 32'h0, 4'hF);
        @(negedge clk);
        chk("mr_gnt_pre", 64'(gnt), 64'h1);
        s_bus.ack = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mr_cyc",  64'(s_bus.cyc),  64'h0);
        chk("mr_gnt",  64'(gnt),        64'h0);
        chk("mr_ack0", 64'(m0_bus.ack), 64'h0);
        @(negedge clk);
        idle_all();
        rst = 1'b0;
        drive(1, 1, 1, 0, 32'h40, 32'h0, 4'hF);
        @(negedge clk);
        chk("mr_m1_gnt", 64'(gnt), 64'h2);
        idle_all();
        @(negedge clk);
        chk("mr_idle", 64'(gnt), 64'h0);

        // Repeated simultaneous requests from IDLE.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 0, 32'h500, 32'h0, 4'hF);
            drive(1, 1, 1, 0, 32'h600, 32'h0, 4'hF);
            @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
            chk($sformatf("tie%0d_gnt", i), 64'(gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
`else
            chk($sformatf("tie%0d_gnt", i), 64'(gnt), 64'h1);
`endif
            idle_all();
            @(negedge clk);
            chk($sformatf("tie%0d_rel", i), 64'(gnt), 64'h0);
        end

        // Random traffic against the reference model, starting from a fresh reset.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        c0 = 0; c1 = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) c0 = ~c0;
            if ($urandom_range(0, 3) == 0) c1 = ~c1;
            drive(0, c0, $urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom, 4'($urandom));
            drive(1, c1, $urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom, 4'($urandom));
            s_bus.ack    = 1'($urandom);
            s_bus.rd_dat = $urandom;
            #1;
            check_outputs();
            model_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
